stream_demux_n: RTL and testbench

- Parametrised, registered 1-to-N stream demultiplexer with a valid/ready handshake. It is the clocked successor to the combinational 1-to-4 demux.
- Routes whole packets from one input stream to one selected output, or to all outputs in broadcast mode.
- Select is latched on the first beat of a packet and held until its last beat.
- Sits between a single packet source and NUM_OUT downstream consumers.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_slot.sv | 52 +++++
 rtl/stream_demux_n.sv | 125 ++++++++++++
 tb/tb_stream_demux_n.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered stream demultiplexer.
// Holds the routing FSM state encoding and the select-width helper.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DROP
    } state_e;

    // At least one select bit, even for a two-way demux.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// Single-entry output register with valid/ready handshake.
// A new load takes priority over a simultaneous drain.
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              free_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-N packet demultiplexer with per-channel output slots.
// Select/broadcast are locked on the first beat of each packet.
module stream_demux_n
    import demux_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NUM_OUT = 4,
    localparam int SEL_W   = sel_width(NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic                      err_sel,
    output logic                      busy
);

    localparam logic [NUM_OUT-1:0] ONE = {{(NUM_OUT-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               bcast_q, bcast_d;
    logic               err_q, err_d;

    logic [SEL_W-1:0]   eff_sel;
    logic               eff_bcast;
    logic               sel_ok;
    logic [NUM_OUT-1:0] tgt;
    logic [NUM_OUT-1:0] slot_free;
    logic [NUM_OUT-1:0] load;
    logic               dropping;
    logic               fire;

    // First beat routes from live inputs, later beats from the lock.
    always_comb begin
        eff_sel   = sel_q;
        eff_bcast = bcast_q;
        if (state_q == IDLE) begin
            eff_sel   = in_sel;
            eff_bcast = in_bcast;
        end
    end

    assign sel_ok = eff_bcast ||
        ({{(32-SEL_W){1'b0}}, eff_sel} < $unsigned(NUM_OUT));

    always_comb begin
        tgt = '0;
        if (eff_bcast)
            tgt = '1;
        else if (sel_ok)
            tgt = ONE << eff_sel;
    end

    assign dropping = (state_q == DROP) || (state_q == IDLE && !sel_ok);
    assign in_ready = dropping || (&(slot_free | ~tgt));
    assign fire     = in_valid && in_ready;
    assign load     = (fire && !dropping) ? tgt : '0;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        bcast_d = bcast_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    sel_d   = in_sel;
                    bcast_d = in_bcast;
                    if (!sel_ok) begin
                        err_d = 1'b1;
                        if (!in_last) state_d = DROP;
                    end else if (!in_last) begin
                        state_d = ROUTE;
                    end
                end
            end
            ROUTE, DROP: begin
                if (fire && in_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            bcast_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            bcast_q <= bcast_d;
            err_q   <= err_d;
        end
    end

    assign err_sel = err_q;
    assign busy    = (state_q != IDLE);

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load[k]),
            .data_i  (in_data),
            .last_i  (in_last),
            .ready_i (out_ready[k]),
            .valid_o (out_valid[k]),
            .data_o  (out_data[k*DATA_W +: DATA_W]),
            .last_o  (out_last[k]),
            .free_o  (slot_free[k])
        );
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n (4-way and 3-way instances).
// Output beats are captured per channel and checked against hand values.
module tb_stream_demux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, in_bcast;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic        err_sel, busy;

    logic        v3, rdy3, last3, bc3;
    logic [7:0]  data3;
    logic [1:0]  sel3;
    logic [2:0]  ov3, or3, ol3;
    logic [23:0] od3;
    logic        err3, busy3;

    int total = 0;
    int bad   = 0;
    int errcnt3 = 0;
    int ovcnt3  = 0;
    logic [8:0] cap [4][$];

    always #5 clk = ~clk;

    stream_demux_n #(.DATA_W(8), .NUM_OUT(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .err_sel(err_sel), .busy(busy)
    );

    stream_demux_n #(.DATA_W(8), .NUM_OUT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(v3), .in_ready(rdy3),
        .in_data(data3), .in_last(last3),
        .in_sel(sel3), .in_bcast(bc3),
        .out_valid(ov3), .out_ready(or3),
        .out_data(od3), .out_last(ol3),
        .err_sel(err3), .busy(busy3)
    );

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (!rst && out_valid[k] && out_ready[k])
                cap[k].push_back({out_last[k], out_data[k*8 +: 8]});
        if (err3) errcnt3++;
        if (ov3 != 3'b000) ovcnt3++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a beat at a negedge, wait for acceptance, return at next negedge.
    task automatic beat(input logic [1:0] s, input logic b,
                        input logic [7:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_sel   = s;
        in_bcast = b;
        in_data  = d;
        in_last  = l;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_cap();
        for (int k = 0; k < 4; k++) cap[k].delete();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_sel = 0; in_bcast = 0; in_data = 0; in_last = 0;
        out_ready = 4'b1111;
        v3 = 0; sel3 = 0; bc3 = 0; data3 = 0; last3 = 0;
        or3 = 3'b111;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_sel, 0);
        rst = 1'b0;
        @(negedge clk);

        // three-beat packet to channel 2
        clear_cap();
        beat(2'd2, 0, 8'hA1, 0);
        chk("t1_v0", out_valid, 4'b0100);
        chk("t1_d0", out_data[23:16], 8'hA1);
        chk("t1_busy", busy, 1);
        beat(2'd2, 0, 8'hA2, 0);
        chk("t1_v1", out_valid, 4'b0100);
        chk("t1_d1", out_data[23:16], 8'hA2);
        beat(2'd2, 0, 8'hA3, 1);
        chk("t1_v2", out_valid, 4'b0100);
        chk("t1_d2", out_data[23:16], 8'hA3);
        chk("t1_last", out_last, 4'b0100);
        chk("t1_idle", busy, 0);
        in_valid = 0;
        @(negedge clk);
        chk("t1_drained", out_valid, 0);
        chk("t1_n", cap[2].size(), 3);
        chk("t1_c2", cap[2][2], 9'h1A3);
        chk("t1_other", cap[0].size() + cap[1].size() + cap[3].size(), 0);

        // select lock: in_sel changes mid-packet
        clear_cap();
        beat(2'd1, 0, 8'hB1, 0);
        chk("t2_busy0", busy, 1);
        beat(2'd3, 0, 8'hB2, 0);
        chk("t2_v1", out_valid, 4'b0010);
        chk("t2_busy1", busy, 1);
        beat(2'd3, 0, 8'hB3, 1);
        chk("t2_busy2", busy, 0);
        in_valid = 0;
        @(negedge clk);
        chk("t2_n1", cap[1].size(), 3);
        chk("t2_c1", cap[1][1], 9'h0B2);
        chk("t2_n3", cap[3].size(), 0);

        // backpressure on channel 0
        clear_cap();
        out_ready = 4'b1110;
        beat(2'd0, 0, 8'hC1, 0);
        in_valid = 1; in_data = 8'hC2; in_last = 0;
        #1;
        chk("t3_stall", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold", {out_valid[0], out_data[7:0]}, 9'h1C1);
        end
        chk("t3_stall2", in_ready, 0);
        out_ready = 4'b1111;
        beat(2'd0, 0, 8'hC2, 0);
        beat(2'd0, 0, 8'hC3, 1);
        in_valid = 0;
        @(negedge clk);
        chk("t3_n", cap[0].size(), 3);
        chk("t3_c0", cap[0][0], 9'h0C1);
        chk("t3_c1", cap[0][1], 9'h0C2);
        chk("t3_c2", cap[0][2], 9'h1C3);

        // broadcast with channel 2 slow
        clear_cap();
        out_ready = 4'b1011;
        beat(2'd0, 1, 8'h55, 0);
        chk("t4_v0", out_valid, 4'b1111);
        chk("t4_d0", out_data, 32'h55555555);
        in_valid = 1; in_data = 8'h66; in_last = 1;
        #1;
        chk("t4_stall0", in_ready, 0);
        @(negedge clk);
        chk("t4_stall1", in_ready, 0);
        chk("t4_v1", out_valid, 4'b0100);
        out_ready = 4'b1111;
        beat(2'd0, 1, 8'h66, 1);
        chk("t4_v2", out_valid, 4'b1111);
        chk("t4_d2", out_data, 32'h66666666);
        chk("t4_last", out_last, 4'b1111);
        in_valid = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("t4_n", cap[k].size(), 2);
            chk("t4_b0", cap[k][0], 9'h055);
            chk("t4_b1", cap[k][1], 9'h166);
        end

        // reset in the middle of a packet
        clear_cap();
        beat(2'd1, 0, 8'hD1, 0);
        chk("t5_v", out_valid, 4'b0010);
        chk("t5_busy", busy, 1);
        rst = 1'b1;
        in_valid = 0;
        #1;
        chk("t5_rv", out_valid, 0);
        chk("t5_rbusy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beat(2'd2, 0, 8'h99, 1);
        chk("t5_v2", out_valid, 4'b0100);
        chk("t5_d2", out_data[23:16], 8'h99);
        chk("t5_idle", busy, 0);
        in_valid = 0;
        @(negedge clk);
        chk("t5_n1", cap[1].size(), 0);
        chk("t5_n2", cap[2].size(), 1);

        // three-way instance: out-of-range select is dropped
        errcnt3 = 0;
        ovcnt3  = 0;
        v3 = 1; sel3 = 2'd3; data3 = 8'hE1; last3 = 0;
        #1;
        chk("t6_rdy0", rdy3, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t6_err", err3, 1);
        chk("t6_busy", busy3, 1);
        chk("t6_nov", ov3, 0);
        sel3 = 2'd0; data3 = 8'hE2; last3 = 1;
        #1;
        chk("t6_rdy1", rdy3, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t6_err_off", err3, 0);
        chk("t6_idle", busy3, 0);
        chk("t6_nov2", ov3, 0);
        data3 = 8'h77;
        @(posedge clk);
        @(negedge clk);
        v3 = 0;
        chk("t6_v", ov3, 3'b001);
        chk("t6_d", od3[7:0], 8'h77);
        repeat (2) @(negedge clk);
        chk("t6_errcnt", errcnt3, 1);
        chk("t6_ovcnt", ovcnt3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
